cook_power_sequencer: RTL and testbench
=======================================

Name: cook_power_sequencer

Overview:
- Controls the oven's cook cycle: start, pause/resume, cancel, completion beeps.
- Duty-cycles the magnetron at a selectable power level (1-10) over a fixed window of 1 Hz ticks.
- Sits between the front-panel buttons/door switch and the magnetron output / minutes-seconds countdown counter.
- Drives the counter's enable and clear, and consumes its zero flag.

Parameters:
- WINDOW, 10, duty window length in 1 Hz ticks; power level N gives N ticks on per window.
- BEEP_COUNT, 3, number of beeps in DONE; each beep is 1 tick on, 1 tick off.

Ports:
- clock  in  1  system clock.
- clearn  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-clock-wide pulse, once per second, synchronous to clock.
- startn  in  1  start button, active-low level, synchronous.
- stopn  in  1  stop/cancel button, active-low level, synchronous.
- door_closed  in  1  1 = door closed.
- timer_zero  in  1  countdown counter reads 0:00.
- power_we  in  1  write strobe for power_in.
- power_in  in  4  requested power level.
- mag_on  out  1  magnetron enable.
- count_en  out  1  countdown counter decrement enable.
- timer_clr  out  1  one-cycle pulse to clear the countdown counter.
- beep  out  1  buzzer drive.
- power_level  out  4  current power level, 1..10.
- state  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (clearn low, asynchronous) sets:
  - state=IDLE, power_level=10, phase_cnt=0, beep_cnt=0, beep=0, timer_clr=0.
  - start/stop history registers set to 1 (no false edge after reset).
- Edge detect:
  - start_ev = prev_startn & ~startn; stop_ev = prev_stopn & ~stopn.
  - History registers update every clock.
  - A held button produces exactly one event.
  - Transitions taken on the same edge that samples the event (1-cycle latency from button fall to state change).
- power_we:
  - Accepted only in IDLE or PAUSE; ignored in COOK and DONE.
  - power_in 1..10 is stored as-is; 0 or 11..15 is stored as 10.
- phase_cnt:
  - Width ceil(log2(WINDOW)).
  - In COOK, increments on tick_1hz and wraps WINDOW-1 -> 0.
  - Holds in PAUSE; cleared on entry to COOK from IDLE.
- mag_on (combinational):
  - = (state==COOK) & door_closed & (phase_cnt < power_level).
  - Door opening drops mag_on in the same cycle, before the state changes.
- count_en = (state==COOK).
- IDLE:
  - start_ev & door_closed & ~timer_zero -> COOK, phase_cnt=0.
  - start_ev with door open or timer_zero: ignored.
  - stop_ev -> timer_clr pulse for 1 cycle, stays IDLE.
- COOK, priority highest first:
  - timer_zero -> DONE, beep_cnt=0.
  - ~door_closed or stop_ev -> PAUSE.
  - Otherwise stay.
- PAUSE:
  - stop_ev -> IDLE with timer_clr pulse (cancel).
  - Else start_ev & door_closed -> COOK, phase_cnt retained (resume mid-window).
  - start_ev with door open: ignored.
- DONE:
  - beep_cnt increments on tick_1hz; beep = ~beep_cnt[0] while beep_cnt < 2*BEEP_COUNT.
  - beep asserts on entry.
  - When beep_cnt reaches 2*BEEP_COUNT: beep=0, -> IDLE.
  - stop_ev or ~door_closed -> IDLE immediately, beep=0 next cycle.
  - start_ev ignored.
- Simultaneous events:
  - start_ev & stop_ev in the same cycle: stop wins in every state.
  - tick_1hz coincident with a COOK->PAUSE transition: phase_cnt does not advance.
- timer_clr is a registered one-cycle pulse, 0 otherwise.
- Reset asserted mid-cook: mag_on and count_en drop asynchronously with the state reset.

Test Plan:
- Reset, power_we=1 with power_in=3 in IDLE, door closed, startn falls, 20 ticks -> state=COOK one clock after fall; mag_on high for ticks 0-2, low 3-9 of each window (6 on-ticks total); count_en=1 throughout.
- power_in=0 and power_in=12 written -> power_level reads 10; in COOK, mag_on stays high across the full window.
- COOK at phase_cnt=5, door opens -> mag_on=0 in the same cycle, state=PAUSE next edge; door closes, start -> COOK resumes at phase_cnt=5.
- PAUSE, stopn falls -> state=IDLE, timer_clr=1 for exactly one clock; holding stopn low for 10 clocks produces no further pulse.
- COOK, timer_zero asserts -> DONE; beep pattern 1,0,1,0,1,0 on successive ticks, then IDLE with beep=0.
- startn and stopn fall in the same cycle in IDLE -> stays IDLE with timer_clr pulse. startn fall with door open -> stays IDLE, mag_on=0.

Source files
------------

// File: rtl/cook_power_sequencer.sv
// Cook-cycle sequencer: start/pause/resume/cancel control, magnetron duty cycling
// over a window of 1 Hz ticks, countdown-counter handshake and completion beeps.
module cook_power_sequencer #(
    parameter int unsigned WINDOW     = 10,
    parameter int unsigned BEEP_COUNT = 3
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       tick_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       timer_zero,
    input  logic       power_we,
    input  logic [3:0] power_in,
    output logic       mag_on,
    output logic       count_en,
    output logic       timer_clr,
    output logic       beep,
    output logic [3:0] power_level,
    output logic [1:0] state
);

    localparam int unsigned PHASE_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned BEEP_LIMIT = 2 * BEEP_COUNT;
    localparam int unsigned BEEP_W     = $clog2(BEEP_LIMIT + 1);
    localparam int unsigned CMP_W      = (PHASE_W > 4) ? PHASE_W : 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic [3:0]          power_q, power_d;
    logic                clr_q, clr_d;
    logic                start_prev_q, stop_prev_q;

    logic                start_ev_c;
    logic                stop_ev_c;
    logic [3:0]          power_clamped_c;

    assign start_ev_c      = start_prev_q & ~startn;
    assign stop_ev_c       = stop_prev_q & ~stopn;
    // Out-of-range requests fall back to full power.
    assign power_clamped_c = ((power_in == 4'd0) || (power_in > 4'd10)) ? 4'd10 : power_in;

    // State and datapath registers
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            beep_cnt_q   <= '0;
            power_q      <= 4'd10;
            clr_q        <= 1'b0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            beep_cnt_q   <= beep_cnt_d;
            power_q      <= power_d;
            clr_q        <= clr_d;
            start_prev_q <= startn;
            stop_prev_q  <= stopn;
        end
    end

    // Next-state and next-datapath logic; stop always outranks start
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        beep_cnt_d = beep_cnt_q;
        power_d    = power_q;
        clr_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (power_we) begin
                    power_d = power_clamped_c;
                end
                if (stop_ev_c) begin
                    clr_d = 1'b1;
                end else if (start_ev_c && door_closed && !timer_zero) begin
                    state_d = ST_COOK;
                    phase_d = '0;
                end
            end

            ST_COOK: begin
                if (timer_zero) begin
                    state_d    = ST_DONE;
                    beep_cnt_d = '0;
                end else if (!door_closed || stop_ev_c) begin
                    // A tick landing on the pause edge is dropped so resume is exact.
                    state_d = ST_PAUSE;
                end else if (tick_1hz) begin
                    if (phase_q == PHASE_W'(WINDOW - 1)) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
            end

            ST_PAUSE: begin
                if (power_we) begin
                    power_d = power_clamped_c;
                end
                if (stop_ev_c) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_ev_c && door_closed) begin
                    state_d = ST_COOK;
                end
            end

            ST_DONE: begin
                if (stop_ev_c || !door_closed) begin
                    state_d = ST_IDLE;
                end else if (beep_cnt_q >= BEEP_W'(BEEP_LIMIT)) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Magnetron and counter enables follow state directly so door/reset act at once.
    assign mag_on      = (state_q == ST_COOK) && door_closed &&
                         (CMP_W'(phase_q) < CMP_W'(power_q));
    assign count_en    = (state_q == ST_COOK);
    assign beep        = (state_q == ST_DONE) && (beep_cnt_q < BEEP_W'(BEEP_LIMIT)) &&
                         !beep_cnt_q[0];
    assign timer_clr   = clr_q;
    assign power_level = power_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cook_power_sequencer.sv
// Scoreboard bench for cook_power_sequencer: directed stimulus queues expected
// output values tagged with a cycle number; a negedge monitor pops and compares.
module tb_cook_power_sequencer;

    logic       clock = 1'b0;
    logic       clearn;
    logic       tick_1hz;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       timer_zero;
    logic       power_we;
    logic [3:0] power_in;
    logic       mag_on;
    logic       count_en;
    logic       timer_clr;
    logic       beep;
    logic [3:0] power_level;
    logic [1:0] state;

    localparam int SIG_STATE = 0;
    localparam int SIG_MAG   = 1;
    localparam int SIG_CEN   = 2;
    localparam int SIG_CLR   = 3;
    localparam int SIG_BEEP  = 4;
    localparam int SIG_POWER = 5;

    typedef struct {
        int unsigned cyc;
        int          id;
        int unsigned val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          stim_done = 1'b0;

    cook_power_sequencer dut (
        .clock       (clock),
        .clearn      (clearn),
        .tick_1hz    (tick_1hz),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .power_we    (power_we),
        .power_in    (power_in),
        .mag_on      (mag_on),
        .count_en    (count_en),
        .timer_clr   (timer_clr),
        .beep        (beep),
        .power_level (power_level),
        .state       (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int unsigned sample(input int id);
        case (id)
            SIG_STATE: return 32'(state);
            SIG_MAG:   return 32'(mag_on);
            SIG_CEN:   return 32'(count_en);
            SIG_CLR:   return 32'(timer_clr);
            SIG_BEEP:  return 32'(beep);
            default:   return 32'(power_level);
        endcase
    endfunction

    // Monitor: compare every expectation due by this cycle, mid-cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int unsigned act;
            e = sb.pop_front();
            act = sample(e.id);
            n_checks++;
            if (act == e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int id, input int unsigned val);
        exp_t e;
        e.cyc  = cyc;
        e.id   = id;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic write_power(input logic [3:0] p);
        power_in = p;
        power_we = 1'b1;
        step();
        power_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        clearn      = 1'b0;
        tick_1hz    = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        door_closed = 1'b1;
        timer_zero  = 1'b0;
        power_we    = 1'b0;
        power_in    = 4'd0;
        step();
        step();
        chk("reset_state", SIG_STATE, 0);
        chk("reset_power", SIG_POWER, 10);
        chk("reset_clr", SIG_CLR, 0);
        chk("reset_beep", SIG_BEEP, 0);
        chk("reset_mag", SIG_MAG, 0);
        chk("reset_cen", SIG_CEN, 0);
        n_checks++;
        if (state === 2'd0) n_pass++;
        else $display("FAIL direct_reset_state: got %0d, expected 0", state);
        n_checks++;
        if (power_level === 4'd10) n_pass++;
        else $display("FAIL direct_reset_power: got %0d, expected 10", power_level);
        clearn = 1'b1;
        step();

        // Power 3 duty cycle over two windows
        write_power(4'd3);
        chk("pw3_level", SIG_POWER, 3);
        startn = 1'b0;
        step();
        chk("start_cook", SIG_STATE, 1);
        n_checks++;
        if (state === 2'd1) n_pass++;
        else $display("FAIL direct_start_cook: got %0d, expected 1", state);
        startn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("duty3_mag", SIG_MAG, ((i % 10) < 3) ? 1 : 0);
            chk("duty3_cen", SIG_CEN, 1);
            tick();
        end

        // Stop while cooking pauses
        stopn = 1'b0;
        step();
        chk("cook_stop_pause", SIG_STATE, 2);
        chk("pause_mag", SIG_MAG, 0);
        chk("pause_cen", SIG_CEN, 0);
        chk("pause_noclr", SIG_CLR, 0);
        stopn = 1'b1;
        step();

        // Power clamping while paused
        write_power(4'd0);
        chk("pw0_clamp", SIG_POWER, 10);
        write_power(4'd7);
        chk("pw7_level", SIG_POWER, 7);
        write_power(4'd12);
        chk("pw12_clamp", SIG_POWER, 10);

        // Resume at full power: on for the whole window
        startn = 1'b0;
        step();
        chk("resume_cook", SIG_STATE, 1);
        startn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("duty10_mag", SIG_MAG, 1);
            tick();
        end
        write_power(4'd2);
        chk("pw_ignored_cook", SIG_POWER, 10);

        // Door opens at phase 5 with a coincident tick
        for (int i = 0; i < 5; i++) tick();
        chk("phase5_mag", SIG_MAG, 1);
        step();
        door_closed = 1'b0;
        tick_1hz = 1'b1;
        chk("door_mag_drop", SIG_MAG, 0);
        chk("door_still_cook", SIG_STATE, 1);
        step();
        tick_1hz = 1'b0;
        chk("door_pause", SIG_STATE, 2);
        door_closed = 1'b1;
        step();
        chk("door_no_autoresume", SIG_STATE, 2);
        write_power(4'd6);
        chk("pw6_level", SIG_POWER, 6);
        startn = 1'b0;
        step();
        chk("door_resume", SIG_STATE, 1);
        chk("resume_phase5_on", SIG_MAG, 1);
        startn = 1'b1;
        tick();
        chk("resume_phase6_off", SIG_MAG, 0);

        // Cancel from pause with held stop
        stopn = 1'b0;
        step();
        chk("stop_to_pause", SIG_STATE, 2);
        stopn = 1'b1;
        step();
        stopn = 1'b0;
        step();
        chk("cancel_idle", SIG_STATE, 0);
        chk("cancel_clr", SIG_CLR, 1);
        n_checks++;
        if (timer_clr === 1'b1) n_pass++;
        else $display("FAIL direct_cancel_clr: got %0d, expected 1", timer_clr);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_stop_noclr", SIG_CLR, 0);
            chk("held_stop_idle", SIG_STATE, 0);
        end
        stopn = 1'b1;
        step();

        // Completion beeps
        startn = 1'b0;
        step();
        chk("start_cook2", SIG_STATE, 1);
        startn = 1'b1;
        timer_zero = 1'b1;
        step();
        timer_zero = 1'b0;
        chk("tz_done", SIG_STATE, 3);
        n_checks++;
        if (state === 2'd3) n_pass++;
        else $display("FAIL direct_tz_done: got %0d, expected 3", state);
        chk("done_cen", SIG_CEN, 0);
        chk("done_mag", SIG_MAG, 0);
        for (int k = 0; k < 6; k++) begin
            chk("beep_pattern", SIG_BEEP, ((k % 2) == 0) ? 1 : 0);
            chk("beep_state", SIG_STATE, 3);
            tick();
        end
        chk("beep_end_off", SIG_BEEP, 0);
        step();
        chk("done_to_idle", SIG_STATE, 0);
        chk("idle_beep_off", SIG_BEEP, 0);

        // Stop during beeping ends DONE at once
        startn = 1'b0;
        step();
        startn = 1'b1;
        timer_zero = 1'b1;
        step();
        timer_zero = 1'b0;
        chk("done2_beep_on", SIG_BEEP, 1);
        stopn = 1'b0;
        step();
        chk("done_stop_idle", SIG_STATE, 0);
        chk("done_stop_beep", SIG_BEEP, 0);
        chk("done_stop_noclr", SIG_CLR, 0);
        stopn = 1'b1;
        step();

        // Simultaneous start and stop in IDLE
        startn = 1'b0;
        stopn  = 1'b0;
        step();
        chk("both_idle", SIG_STATE, 0);
        chk("both_clr", SIG_CLR, 1);
        startn = 1'b1;
        stopn  = 1'b1;
        step();

        // Start ignored with door open or timer at zero
        door_closed = 1'b0;
        startn = 1'b0;
        step();
        chk("door_open_idle", SIG_STATE, 0);
        chk("door_open_mag", SIG_MAG, 0);
        startn = 1'b1;
        door_closed = 1'b1;
        step();
        timer_zero = 1'b1;
        startn = 1'b0;
        step();
        chk("tz_start_idle", SIG_STATE, 0);
        startn = 1'b1;
        timer_zero = 1'b0;
        step();

        // Asynchronous reset mid-cook
        startn = 1'b0;
        step();
        startn = 1'b1;
        chk("cook3_mag", SIG_MAG, 1);
        step();
        #2;
        clearn = 1'b0;
        #1;
        chk("areset_state", SIG_STATE, 0);
        chk("areset_mag", SIG_MAG, 0);
        chk("areset_cen", SIG_CEN, 0);
        chk("areset_power", SIG_POWER, 10);
        step();
        clearn = 1'b1;
        step();
        step();

        stim_done = 1'b1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            $display("FAIL %s: not compared, expected %0d", e.name, e.val);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
